// File: rtl/tinker_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tinker_muldiv_unit: radix-2 iterative MUL/MULH/DIV/REM with valid/ready;  |
// | signed support under TINKER_MULDIV_SIGNED_EN.   Revision: 1.0            |
// +--------------------------------------------------------------------------+
module tinker_muldiv_unit #(
  parameter int W     = 64,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic         is_signed,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [4:0]   rd_tag,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   rd_tag_out,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(W);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             bzero_q, bzero_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     result_q, result_d;
  logic [4:0]       tag_q, tag_d;
  logic             dbz_q, dbz_d;

  logic [W-1:0]     w_a_mag, w_b_mag;
  logic [2*W-1:0]   w_prod_fix;
  logic [W-1:0]     w_quo_fix, w_rem_fix;

`ifdef TINKER_MULDIV_SIGNED_EN
  logic neg_q, neg_d;
  logic w_sa, w_sb, w_neg_new;

  assign w_sa      = is_signed & op_a[W-1];
  assign w_sb      = is_signed & op_b[W-1];
  assign w_a_mag   = w_sa ? -op_a : op_a;
  assign w_b_mag   = w_sb ? -op_b : op_b;
  // A zero divisor must yield an all-ones quotient, so its sign is never applied.
  assign w_neg_new = (op == 2'b11) ? w_sa
                                   : ((w_sa ^ w_sb) & ~(op[1] & (op_b == '0)));
  assign w_prod_fix = neg_q ? -acc_q : acc_q;
  assign w_quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign w_rem_fix  = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign w_a_mag    = op_a;
  assign w_b_mag    = op_b;
  assign w_prod_fix = acc_q;
  assign w_quo_fix  = acc_q[W-1:0];
  assign w_rem_fix  = acc_q[2*W-1:W];
`endif

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  logic [W:0]       w_mul_hi;
  logic [2*W-1:0]   w_mul_next;
  assign w_mul_hi   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
  assign w_mul_next = {w_mul_hi, acc_q[W-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  logic [W:0]       w_shift;
  logic             w_ge;
  logic [W-1:0]     w_sub;
  logic [2*W-1:0]   w_div_next;
  assign w_shift    = {acc_q[2*W-1:W], acc_q[W-1]};
  assign w_ge       = (w_shift >= {1'b0, opb_q});
  assign w_sub      = w_shift[W-1:0] - opb_q;
  assign w_div_next = {(w_ge ? w_sub : w_shift[W-1:0]), acc_q[W-2:0], w_ge};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    bzero_d  = bzero_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    tag_d    = tag_q;
    dbz_d    = dbz_q;
`ifdef TINKER_MULDIV_SIGNED_EN
    neg_d    = neg_q;
`endif
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d = S_RUN;
            cnt_d   = c_cnt_init;
            op_d    = op;
            tag_d   = rd_tag;
            bzero_d = (op_b == '0);
            opb_d   = w_b_mag;
            acc_d   = {{W{1'b0}}, w_a_mag};
`ifdef TINKER_MULDIV_SIGNED_EN
            neg_d   = w_neg_new;
`endif
          end
        end
        S_RUN: begin
          cnt_d = cnt_q - c_cnt_last;
          acc_d = op_q[1] ? w_div_next : w_mul_next;
          if (cnt_q == c_cnt_last) state_d = S_FIX;
        end
        S_FIX: begin
          case (op_q)
            2'b00:   result_d = w_prod_fix[W-1:0];
            2'b01:   result_d = w_prod_fix[2*W-1:W];
            2'b10:   result_d = w_quo_fix;
            default: result_d = w_rem_fix;
          endcase
          dbz_d   = op_q[1] & bzero_q;
          state_d = S_DONE;
        end
        default: begin
          if (out_ready) state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      bzero_q  <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
      dbz_q    <= 1'b0;
`ifdef TINKER_MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      bzero_q  <= bzero_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      dbz_q    <= dbz_d;
`ifdef TINKER_MULDIV_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign rd_tag_out  = tag_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_tinker_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tinker_muldiv_unit: self-checking bench for tinker_muldiv_unit (W=64). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tinker_muldiv_unit;

`ifdef TINKER_MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, is_signed, flush, out_valid, out_ready, div_by_zero;
  logic [1:0]  op;
  logic [63:0] op_a, op_b, result;
  logic [4:0]  rd_tag, rd_tag_out;

  int n_checks = 0;
  int n_pass   = 0;

  tinker_muldiv_unit #(.W(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .is_signed(is_signed), .op_a(op_a), .op_b(op_b), .rd_tag(rd_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_tag_out(rd_tag_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: plain arithmetic on the architectural values; returns {div_by_zero, result}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic s,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  q, r;
    logic         sg;
    sg = SIGNED_EN && s;
    if (sg) p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    else    p = {64'b0, a} * {64'b0, b};
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (sg && a == MIN_NEG && b == '1) begin
      q = MIN_NEG;
      r = 64'd0;
    end else if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    case (o)
      2'b00:   return {1'b0, p[63:0]};
      2'b01:   return {1'b0, p[127:64]};
      2'b10:   return {b == 64'd0, q};
      default: return {b == 64'd0, r};
    endcase
  endfunction

  logic [64:0] last_exp;

  task automatic run_op(input string nm, input logic [1:0] o, input logic s,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
    int lat;
    last_exp = model(o, s, a, b);
    check({nm, "_in_ready"}, in_ready, 1);
    op = o; is_signed = s; op_a = a; op_b = b; rd_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 65);
    check({nm, "_result"}, result, last_exp[63:0]);
    check({nm, "_dbz"}, div_by_zero, last_exp[64]);
    check({nm, "_tag"}, rd_tag_out, t);
  endtask

  task automatic release_result(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_idle_after_hs"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b;
    logic [1:0]  o;
    reset = 1'b1; in_valid = 0; op = 0; is_signed = 0; op_a = 0; op_b = 0;
    rd_tag = 0; flush = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_outs", {out_valid, div_by_zero, rd_tag_out, result}, 0);

    run_op("mul_basic", 2'b00, 1'b0, 64'h1_0000_0001, 64'h3, 5'd1);
    release_result("mul_basic");
    run_op("mulh_ones", 2'b01, 1'b0, '1, '1, 5'd2);
    release_result("mulh_ones");
    run_op("mul_ones", 2'b00, 1'b0, '1, '1, 5'd3);
    release_result("mul_ones");
    run_op("div_100_7", 2'b10, 1'b0, 64'd100, 64'd7, 5'd4);
    release_result("div_100_7");
    run_op("rem_100_7", 2'b11, 1'b0, 64'd100, 64'd7, 5'd5);
    release_result("rem_100_7");
`ifdef TINKER_MULDIV_SIGNED_EN
    run_op("sdiv_m7_2", 2'b10, 1'b1, -64'sd7, 64'd2, 5'd6);
    release_result("sdiv_m7_2");
    run_op("srem_m7_2", 2'b11, 1'b1, -64'sd7, 64'd2, 5'd7);
    release_result("srem_m7_2");
    run_op("sdiv_ovf", 2'b10, 1'b1, MIN_NEG, '1, 5'd8);
    release_result("sdiv_ovf");
`endif

    // Consumer stalls: DONE must hold everything steady.
    run_op("stall", 2'b00, 1'b0, 64'hDEAD_BEEF, 64'h1234_5678, 5'd9);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_result", result, last_exp[63:0]);
      check("stall_hold", {out_valid, in_ready, rd_tag_out}, {2'b10, 5'd9});
    end
    release_result("stall");

    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 50));
        2:       b = '1;
        default: b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) a = MIN_NEG;
      o = 2'($urandom_range(0, 3));
      run_op("rand", o, 1'($urandom_range(0, 1)), a, b, 5'($urandom));
      release_result("rand");
    end

    // Flush at edge N+20 of a divide.
    op = 2'b10; is_signed = 0; op_a = 64'd1000; op_b = 64'd3; rd_tag = 5'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {out_valid, in_ready}, 2'b01);
    begin
      logic seen;
      seen = 1'b0;
      repeat (80) begin
        @(posedge clk); #1;
        seen = seen | out_valid;
      end
      check("flush_no_result", seen, 0);
    end

    // Leave nonzero outputs behind, then reset mid-RUN.
    run_op("div0", 2'b10, 1'b0, 64'd5, 64'd0, 5'd21);
    release_result("div0");
    run_op("rem0", 2'b11, 1'b0, 64'd5, 64'd0, 5'd22);
    release_result("rem0");
    op = 2'b00; op_a = 64'd77; op_b = 64'd99; rd_tag = 5'd30; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrun_reset_ready", in_ready, 1);
    check("midrun_reset_outs", {out_valid, div_by_zero, rd_tag_out, result}, 0);
    run_op("after_reset", 2'b01, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 5'd17);
    release_result("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
